// File: rtl/spi_slave_controller.sv
//------------------------------------------------------------------------------
// Module     : spi_slave_controller
// Description: SPI mode-0 slave byte engine (MSB first, 8-bit), oversampled on clk.
//              Optional status flags when SPI_SLAVE_STATUS_EN is defined.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_slave_controller #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic       status_clear,
    input  logic       rx_ack,
    output logic       tx_underrun,
    output logic       rx_overrun
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;

    logic       w_cs;
    logic       w_sck;
    logic       w_mosi;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sck_rise;
    logic       w_sck_fall;

    logic       w_byte_start;
    logic       w_frame_end;
    logic       w_shift_in;
    logic       w_shift_out;
    logic       w_rx_done;

    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [6:0] r_tx_shift;
    logic [6:0] r_rx_shift;
    logic [3:0] r_bit_cnt;
    logic       r_miso;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_cs_rise  = ~r_cs_d & w_cs;
    assign w_sck_rise = ~r_sck_d & w_sck;
    assign w_sck_fall = r_sck_d & ~w_sck;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_d      <= w_cs;
            r_sck_d     <= w_sck;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A chip-select rise pre-empts any sck edge seen in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_start = 1'b0;
        w_frame_end  = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_byte_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end else if (w_sck_rise) begin
                    w_shift_in = 1'b1;
                end else if (w_sck_fall) begin
                    if (r_bit_cnt == 4'd8) begin
                        w_byte_start = 1'b1;
                    end else if (r_bit_cnt != 4'd0) begin
                        w_shift_out = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rx_done = w_shift_in && (r_bit_cnt == 4'd7);

    // Holding-register capture needs it empty and consumption needs it full,
    // so the two never collide in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_tx_shift  <= 7'h00;
            r_rx_shift  <= 7'h00;
            r_bit_cnt   <= 4'd0;
            r_miso      <= 1'b1;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
            if (w_frame_end) begin
                r_miso    <= 1'b1;
                r_bit_cnt <= 4'd0;
            end
            if (w_byte_start) begin
                r_bit_cnt <= 4'd0;
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold[6:0];
                    r_miso      <= r_hold[7];
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift <= IDLE_TX_BYTE[6:0];
                    r_miso     <= IDLE_TX_BYTE[7];
                end
            end
            if (w_shift_out) begin
                r_miso     <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
            end
            if (w_shift_in) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
            if (w_rx_done) begin
                r_rx_data  <= {r_rx_shift, w_mosi};
                r_rx_valid <= 1'b1;
            end
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = (r_state == ST_ACTIVE);
    assign busy     = (r_state == ST_ACTIVE);
    assign tx_ready = ~r_hold_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_STATUS_EN
    logic r_rx_pending;
    logic r_tx_underrun;
    logic r_rx_overrun;

    // Set events take priority over status_clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_pending  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            if (w_rx_done) begin
                r_rx_pending <= 1'b1;
            end else if (rx_ack) begin
                r_rx_pending <= 1'b0;
            end
            if (w_byte_start && !r_hold_full) begin
                r_tx_underrun <= 1'b1;
            end else if (status_clear) begin
                r_tx_underrun <= 1'b0;
            end
            if (w_rx_done && r_rx_pending && !rx_ack) begin
                r_rx_overrun <= 1'b1;
            end else if (status_clear) begin
                r_rx_overrun <= 1'b0;
            end
        end
    end

    assign tx_underrun = r_tx_underrun;
    assign rx_overrun  = r_rx_overrun;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_controller.sv
//------------------------------------------------------------------------------
// Module     : tb_spi_slave_controller
// Description: Self-checking bench for spi_slave_controller with a mode-0 master.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_controller;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clear = 1'b0;
    logic       rx_ack = 1'b0;
    logic       tx_underrun;
    logic       rx_overrun;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];

    logic [7:0] f_mosi[8];
    logic [7:0] f_tx[8];
    logic [7:0] f_miso[8];
    bit         f_has[8];
    int         f_n;
    int         last_rise_cyc;
    int         bad_busy;
    int         cur_byte;

    spi_slave_controller #(
        .SYNC_STAGES (SYNC),
        .IDLE_TX_BYTE(8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sck     (sck),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy)
`ifdef SPI_SLAVE_STATUS_EN
        ,
        .status_clear(status_clear),
        .rx_ack      (rx_ack),
        .tx_underrun (tx_underrun),
        .rx_overrun  (rx_overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL load_tx_timeout: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master: mosi changes while sck is low, miso is sampled on the rise.
    task automatic run_frame();
        bad_busy = 0;
        cur_byte = -1;
        if (f_has[0]) load_tx(f_tx[0]);
        fork
            begin : master
                cs_n = 1'b0;
                for (int b = 0; b < f_n; b++) begin
                    logic [7:0] rd;
                    rd = 8'h00;
                    for (int i = 7; i >= 0; i--) begin
                        mosi = f_mosi[b][i];
                        clk_wait(HALF);
                        sck = 1'b1;
                        rd[i] = miso;
                        last_rise_cyc = cyc;
                        if (busy !== 1'b1 || miso_oe !== 1'b1) bad_busy++;
                        cur_byte = b;
                        clk_wait(HALF);
                        sck = 1'b0;
                    end
                    f_miso[b] = rd;
                end
                clk_wait(HALF);
                cs_n = 1'b1;
                mosi = 1'b0;
            end
            begin : loader
                for (int k = 1; k < f_n; k++) begin
                    if (f_has[k]) begin
                        wait (cur_byte >= k - 1);
                        load_tx(f_tx[k]);
                    end
                end
            end
        join
        clk_wait(10);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sck      = 1'($urandom);
            cs_n     = 1'($urandom);
            mosi     = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
        end
        @(negedge clk);
        checks += 6;
        if (miso !== 1'b1)     begin errors++; $display("FAIL reset_miso: got %b want 1", miso); end
        if (miso_oe !== 1'b0)  begin errors++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_valid = 1'b0;
        clk_wait(SYNC + 3);
        reset = 1'b1;
        clk_wait(5);
    endtask

    task automatic test_single_byte();
        rx_q.delete(); rx_cyc.delete();
        f_n = 1; f_mosi[0] = 8'h3C; f_tx[0] = 8'hA5; f_has[0] = 1'b0;
        load_tx(8'hA5);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_tx_ready_after_load: got %b want 0", tx_ready); end
        run_frame();
        checks += 8;
        if (f_miso[0] !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h want a5", f_miso[0]); end
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            errors++; $display("FAIL single_rx: pulses %0d first %h want 1 pulse 3c", rx_q.size(), rx_q[0]);
        end
        if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data_held: got %h want 3c", rx_data); end
        if (rx_cyc.size() != 1 || rx_cyc[0] - last_rise_cyc != SYNC + 1) begin
            errors++; $display("FAIL single_latency: got %0d want %0d", rx_cyc[0] - last_rise_cyc, SYNC + 1);
        end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready: got %b want 1", tx_ready); end
        if (bad_busy != 0) begin errors++; $display("FAIL single_busy_in_frame: %0d low samples want 0", bad_busy); end
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            errors++; $display("FAIL single_idle_after: busy=%b oe=%b want 0 0", busy, miso_oe);
        end
        if (miso !== 1'b1) begin errors++; $display("FAIL single_miso_idle: got %b want 1", miso); end
    endtask

    task automatic test_back_to_back();
        rx_q.delete(); rx_cyc.delete();
        f_n = 2;
        f_mosi[0] = 8'hC3; f_mosi[1] = 8'h5A;
        f_tx[0] = 8'h11;   f_tx[1] = 8'h22;
        f_has[0] = 1'b1;   f_has[1] = 1'b1;
        run_frame();
        checks += 3;
        if (f_miso[0] !== 8'h11 || f_miso[1] !== 8'h22) begin
            errors++; $display("FAIL b2b_miso: got %h %h want 11 22", f_miso[0], f_miso[1]);
        end
        if (rx_q.size() != 2) begin
            errors++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size());
        end else if (rx_q[0] !== 8'hC3 || rx_q[1] !== 8'h5A) begin
            errors++; $display("FAIL b2b_rx: got %h %h want c3 5a", rx_q[0], rx_q[1]);
        end
        if (bad_busy != 0) begin errors++; $display("FAIL b2b_busy: %0d low samples want 0", bad_busy); end
    endtask

    task automatic test_no_tx();
        rx_q.delete(); rx_cyc.delete();
`ifdef SPI_SLAVE_STATUS_EN
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
`endif
        f_n = 1; f_mosi[0] = 8'h00; f_has[0] = 1'b0;
        run_frame();
        checks += 2;
        if (f_miso[0] !== 8'hFF) begin errors++; $display("FAIL notx_miso: got %h want ff", f_miso[0]); end
        if (rx_q.size() != 1 || rx_q[0] !== 8'h00) begin
            errors++; $display("FAIL notx_rx: pulses %0d first %h want 1 pulse 00", rx_q.size(), rx_q[0]);
        end
`ifdef SPI_SLAVE_STATUS_EN
        checks++;
        if (tx_underrun !== 1'b1) begin errors++; $display("FAIL notx_underrun: got %b want 1", tx_underrun); end
`endif
    endtask

    task automatic test_abort();
        rx_q.delete(); rx_cyc.delete();
        cs_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom);
            clk_wait(HALF);
            sck = 1'b1;
            clk_wait(HALF);
            sck = 1'b0;
        end
        clk_wait(HALF);
        cs_n = 1'b1;
        clk_wait(10);
        checks += 3;
        if (rx_q.size() != 0) begin errors++; $display("FAIL abort_rx_valid: got %0d pulses want 0", rx_q.size()); end
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b oe=%b want 0 0", busy, miso_oe);
        end
        if (miso !== 1'b1) begin errors++; $display("FAIL abort_miso: got %b want 1", miso); end
        f_n = 1; f_mosi[0] = 8'h96; f_has[0] = 1'b0;
        run_frame();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
            errors++; $display("FAIL abort_next_frame: pulses %0d first %h want 1 pulse 96", rx_q.size(), rx_q[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_q.delete(); rx_cyc.delete();
        cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'($urandom);
            clk_wait(HALF);
            sck = 1'b1;
            clk_wait(HALF);
            sck = 1'b0;
        end
        reset = 1'b0;
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        clk_wait(3);
        reset = 1'b1;
        clk_wait(5);
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_spurious: got %0d pulses want 0", rx_q.size()); end
        f_n = 1; f_mosi[0] = 8'h7E; f_has[0] = 1'b0;
        run_frame();
        checks += 2;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin
            errors++; $display("FAIL rstmid_rx: pulses %0d first %h want 1 pulse 7e", rx_q.size(), rx_q[0]);
        end
        if (rx_data !== 8'h7E) begin errors++; $display("FAIL rstmid_rx_data: got %h want 7e", rx_data); end
    endtask

    // Reference: each byte slot returns its queued tx byte or the idle byte,
    // and every mosi byte appears once on rx in order.
    task automatic test_random();
        logic [7:0] exp_miso;
        for (int fr = 0; fr < 5; fr++) begin
            rx_q.delete(); rx_cyc.delete();
            f_n = $urandom_range(1, 4);
            for (int b = 0; b < f_n; b++) begin
                f_mosi[b] = 8'($urandom);
                f_tx[b]   = 8'($urandom);
                f_has[b]  = 1'($urandom);
            end
            run_frame();
            checks++;
            if (rx_q.size() != f_n) begin
                errors++; $display("FAIL rand_rx_count: frame %0d got %0d want %0d", fr, rx_q.size(), f_n);
            end
            for (int b = 0; b < f_n; b++) begin
                exp_miso = f_has[b] ? f_tx[b] : 8'hFF;
                checks += 2;
                if (f_miso[b] !== exp_miso) begin
                    errors++; $display("FAIL rand_miso: frame %0d byte %0d got %h want %h", fr, b, f_miso[b], exp_miso);
                end
                if (b >= rx_q.size() || rx_q[b] !== f_mosi[b]) begin
                    errors++; $display("FAIL rand_rx: frame %0d byte %0d got %h want %h", fr, b, rx_q[b], f_mosi[b]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_no_tx();
        test_abort();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
